div32_seq: RTL

- Multi-cycle 32-bit restoring divider.
- Acts as the inverse counterpart of the team's combinational add/sub ALU: it consumes operands and repeatedly uses trial subtraction, one quotient bit per clock.
- Supports signed (two's complement) and unsigned division.
- Reports quotient, remainder and zero/div-by-zero/overflow flags through a start/busy/done handshake.
- Sits beside the ALU in the execute stage.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 34 +++
 rtl/div32_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   state_e   : divider FSM states
//   DIV_WIDTH : default operand/result width
//   MIN_INT   : most negative signed value at DIV_WIDTH
//   ALL_ONES  : all-ones word at DIV_WIDTH (-1 signed, divide-by-zero quotient)
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] MIN_INT  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (combinational).
//   rem      : current partial remainder (always < divisor)
//   dvd_msb  : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The shifted remainder keeps rem's MSB: with divisors >= 2^(WIDTH-1)
    // the partial remainder can itself have its top bit set, so the shift
    // needs WIDTH+1 bits to stay exact.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_shift = {rem, dvd_msb};
        diff      = rem_shift - {1'b0, divisor};
        // A set top bit in rem_shift means it already exceeds any divisor;
        // otherwise diff[WIDTH] is a valid borrow.
        q_bit     = rem_shift[WIDTH] | ~diff[WIDTH];
        // When the subtraction succeeds the result is below the divisor and
        // fits WIDTH bits; when it fails rem_shift is below the divisor too.
        rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring divider, one quotient bit per clock.
// Signed (truncating, remainder takes dividend sign) and unsigned modes.
//   clk, rst          : clock, synchronous active-high reset
//   start, signed_op  : request and mode, sampled when idle
//   a, b              : dividend, divisor
//   busy              : FSM not idle
//   done              : one-cycle pulse, results valid
//   quotient/remainder: registered results
//   zero              : final quotient is zero
//   div_zero          : divisor was zero
//   overflow          : signed MIN_INT / -1
import div_pkg::*;

module div32_seq #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             div_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_W = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] a_raw_q, a_raw_d; // raw dividend for divide-by-zero remainder
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;       // special path: divide by zero
    logic             ovf_q, ovf_d;     // special path: signed overflow
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             zero_q, zero_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] abs_a, abs_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .divisor  (dsr_q),
        .rem_next (step_rem),
        .q_bit    (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        a_raw_d     = a_raw_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        zero_d      = zero_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        abs_a       = (signed_op && a[WIDTH-1]) ? -a : a;
        abs_b       = (signed_op && b[WIDTH-1]) ? -b : b;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d      = abs_a;
                    dsr_d      = abs_b;
                    rem_d      = '0;
                    count_d    = '0;
                    a_raw_d    = a;
                    qneg_d     = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d     = signed_op & a[WIDTH-1];
                    dz_d       = (b == '0);
                    ovf_d      = signed_op && (a == MIN_W) && (b == ONES_W);
                    // Flags clear on accept; results hold until FIX.
                    zero_d     = 1'b0;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = (dz_d || ovf_d) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_qbit};
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH-1))
                    state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d  = ONES_W;
                    remainder_d = a_raw_q;
                    div_zero_d  = 1'b1;
                end else if (ovf_q) begin
                    quotient_d  = MIN_W;
                    remainder_d = '0;
                    overflow_d  = 1'b1;
                end else begin
                    quotient_d  = qneg_q ? -dvd_q : dvd_q;
                    remainder_d = rneg_q ? -rem_q : rem_q;
                end
                zero_d  = (quotient_d == '0);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            a_raw_q     <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            a_raw_q     <= a_raw_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            zero_q      <= zero_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign zero      = zero_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule
